// File: rtl/cpu_run_ctrl.sv
// Run-control FSM: gates pipeline advance from host commands and the writeback stream.
// Optional watchdog enabled by defining CPU_CTRL_WDOG_EN.
module cpu_run_ctrl #(
  parameter int unsigned              IR_WIDTH   = 16,
  parameter int unsigned              OP_MSB     = 15,
  parameter int unsigned              OP_LSB     = 11,
  parameter logic [OP_MSB-OP_LSB:0]   HALT_OP    = 5'b00001,
  parameter int unsigned              CNT_WIDTH  = 16,
  parameter int unsigned              WDOG_LIMIT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 step,
  input  logic                 pause,
  input  logic                 resume,
  input  logic                 wb_valid,
  input  logic [IR_WIDTH-1:0]  wb_ir,
  output logic [2:0]           state,
  output logic                 run,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 wdog_trip
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 is_halt;
  logic                 launch;
  logic                 wdog_fire;

  assign is_halt = wb_valid && (wb_ir[OP_MSB:OP_LSB] == HALT_OP);
  assign launch  = (state_q == IDLE) && enable && start;
  assign run     = (state_q == RUN) || (state_q == STEP);
  assign halted  = (state_q == HALT);
  assign state   = state_q;
  assign retired = retired_q;

`ifdef CPU_CTRL_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT) + 1;

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_trip_q;
  logic              unused_bits;

  assign wdog_fire = run && !wb_valid && (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));
  assign wdog_trip = wdog_trip_q;
  assign unused_bits = ^wb_ir;

  // Counter restarts on every retirement and on each fresh entry into RUN/STEP
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
    end else if (!((state_d == RUN) || (state_d == STEP)) || (state_d != state_q) || wb_valid) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_trip_q <= 1'b0;
    end else if (launch) begin
      wdog_trip_q <= 1'b0;
    end else if (enable && wdog_fire) begin
      wdog_trip_q <= 1'b1;
    end
  end
`else
  logic unused_bits;

  assign wdog_fire   = 1'b0;
  assign wdog_trip   = 1'b0;
  assign unused_bits = ^{wb_ir, (WDOG_LIMIT == 0)};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && start)     state_d = RUN;
        else if (enable && step) state_d = STEP;
      end
      RUN: begin
        if (!enable)        state_d = IDLE;
        else if (wdog_fire) state_d = IDLE;
        else if (is_halt)   state_d = HALT;
        else if (pause)     state_d = PAUSE;
      end
      STEP: begin
        if (!enable)        state_d = IDLE;
        else if (wdog_fire) state_d = IDLE;
        else if (is_halt)   state_d = HALT;
        else if (wb_valid)  state_d = PAUSE;
      end
      PAUSE: begin
        if (!enable)     state_d = IDLE;
        else if (resume) state_d = RUN;
        else if (step)   state_d = STEP;
      end
      HALT: begin
        if (!enable || start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear on launch outranks the increment; the count saturates rather than wraps
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (launch) begin
      retired_q <= '0;
    end else if (run && wb_valid && !(&retired_q)) begin
      retired_q <= retired_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed table, corner sequences and a random run
// against a behavioural model; watchdog expectations follow CPU_CTRL_WDOG_EN.
module tb_cpu_run_ctrl;

  localparam int WL = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, start = 1'b0, step = 1'b0, pause = 1'b0, resume = 1'b0;
  logic        wb_valid = 1'b0;
  logic [15:0] wb_ir = '0;

  logic [2:0]  state, state4;
  logic        run, run4, halted, halted4, wdog_trip, wdog_trip4;
  logic [15:0] retired;
  logic [3:0]  retired4;

  int checks = 0;
  int failures = 0;

  int     m_state;
  longint m_ret, m_ret4;
  bit     m_trip;
  int     m_quiet;

  typedef struct {
    bit       en, st, sp, pa, re, wv;
    bit [4:0] op;
    int       exp_state;
    int       exp_ret;
  } vec_t;

  vec_t vt[$];

  cpu_run_ctrl #(.CNT_WIDTH(16), .WDOG_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .step(step),
    .pause(pause), .resume(resume), .wb_valid(wb_valid), .wb_ir(wb_ir),
    .state(state), .run(run), .halted(halted), .retired(retired), .wdog_trip(wdog_trip)
  );

  cpu_run_ctrl #(.CNT_WIDTH(4), .WDOG_LIMIT(WL)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .step(step),
    .pause(pause), .resume(resume), .wb_valid(wb_valid), .wb_ir(wb_ir),
    .state(state4), .run(run4), .halted(halted4), .retired(retired4), .wdog_trip(wdog_trip4)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit st, input bit sp, input bit pa,
                       input bit re, input bit wv, input bit [4:0] op);
    enable   = en;
    start    = st;
    step     = sp;
    pause    = pa;
    resume   = re;
    wb_valid = wv;
    wb_ir    = {op, 11'($urandom)};
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ret   = 0;
    m_ret4  = 0;
    m_trip  = 0;
    m_quiet = 0;
  endtask

  // Rules applied directly from the state-transition table; states are plain integers
  task automatic model_step();
    bit busy, halt_ins, fire, launch;
    int ns;
    busy     = (m_state == 1) || (m_state == 2);
    halt_ins = wb_valid && (wb_ir[15:11] == 5'b00001);
    launch   = (m_state == 0) && enable && start;
    fire     = 1'b0;
`ifdef CPU_CTRL_WDOG_EN
    fire = busy && !wb_valid && (m_quiet == WL - 1);
`endif
    ns = m_state;
    if (m_state == 0) begin
      if (enable && start) ns = 1;
      else if (enable && step) ns = 2;
    end else if (m_state == 1) begin
      if (!enable || fire) ns = 0;
      else if (halt_ins) ns = 4;
      else if (pause) ns = 3;
    end else if (m_state == 2) begin
      if (!enable || fire) ns = 0;
      else if (halt_ins) ns = 4;
      else if (wb_valid) ns = 3;
    end else if (m_state == 3) begin
      if (!enable) ns = 0;
      else if (resume) ns = 1;
      else if (step) ns = 2;
    end else begin
      if (!enable || start) ns = 0;
    end
    if (launch) begin
      m_ret  = 0;
      m_ret4 = 0;
    end else if (busy && wb_valid) begin
      if (m_ret < 65535) m_ret++;
      if (m_ret4 < 15) m_ret4++;
    end
    if (launch) m_trip = 0;
    else if (enable && fire) m_trip = 1;
    if (((ns == 1) || (ns == 2)) && (ns == m_state) && !wb_valid) m_quiet++;
    else m_quiet = 0;
    m_state = ns;
  endtask

  task automatic model_check();
    chk("state", state, m_state);
    chk("state4", state4, m_state);
    chk("run", run, (m_state == 1) || (m_state == 2));
    chk("halted", halted, m_state == 4);
    chk("retired", retired, m_ret);
    chk("retired4", retired4, m_ret4);
    chk("wdog_trip", wdog_trip, m_trip);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    model_check();
  endtask

  function automatic vec_t mk(bit en, bit st, bit sp, bit pa, bit re, bit wv,
                              bit [4:0] op, int es, int er);
    vec_t v;
    v.en = en; v.st = st; v.sp = sp; v.pa = pa; v.re = re; v.wv = wv;
    v.op = op; v.exp_state = es; v.exp_ret = er;
    return v;
  endfunction

  initial begin
    #1 reset = 1'b0;
    model_reset();
    #10;
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_run", run, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wdog", wdog_trip, 0);
    @(negedge clock);
    reset = 1'b1;

    // en st sp pa re wv op  -> state retired
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 5'd0, 1, 0));
    for (int i = 1; i <= 10; i++) vt.push_back(mk(1, 0, 0, 0, 0, 1, 5'd3, 1, i));
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 5'b00001, 4, 11));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 5'd0, 4, 11));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 5'd0, 0, 11));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 5'd0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 5'd0, 3, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 5'd2, 3, 0));
    vt.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 2, 0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 0, 0, 0, 0, 0, 5'b00001, 2, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 5'd6, 3, 1));
    vt.push_back(mk(1, 0, 1, 0, 1, 0, 5'd0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 1));
    vt.push_back(mk(1, 0, 1, 0, 0, 0, 5'd0, 2, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 5'b00001, 4, 2));

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].st, vt[i].sp, vt[i].pa, vt[i].re, vt[i].wv, vt[i].op);
      tick();
      chk($sformatf("tbl%0d_state", i), state, vt[i].exp_state);
      chk($sformatf("tbl%0d_retired", i), retired, vt[i].exp_ret);
      chk($sformatf("tbl%0d_run", i), run, (vt[i].exp_state == 1) || (vt[i].exp_state == 2));
    end

    // HALT -> IDLE by dropping enable, then relaunch and saturate the narrow counter
    drive(0, 0, 0, 0, 0, 0, 5'd0);
    tick();
    chk("halt_to_idle", state, 0);
    drive(1, 1, 0, 0, 0, 0, 5'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5'd7);
      tick();
    end
    chk("sat_retired4", retired4, 15);
    chk("sat_retired16", retired, 20);

    drive(1, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < WL; i++) tick();
`ifdef CPU_CTRL_WDOG_EN
    chk("wdog_state", state, 0);
    chk("wdog_trip_set", wdog_trip, 1);
`else
    chk("wdog_state", state, 1);
    chk("wdog_trip_set", wdog_trip, 0);
`endif
    drive(1, 1, 0, 0, 0, 0, 5'd0);
    tick();
    chk("wdog_restart_state", state, 1);
    chk("wdog_trip_clear", wdog_trip, 0);

    // Asynchronous reset between edges while running with a nonzero count
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5'd9);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_retired", retired, 0);
    chk("arst_retired4", retired4, 0);
    chk("arst_run", run, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 19) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0,
            ($urandom_range(0, 9) == 0) ? 5'b00001 : 5'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run-control FSM for the CPU core. It gates pipeline advance (`run`) from external enable/start/step/pause/resume commands and from the writeback instruction stream.
- Generalises instruction width, opcode field position and HALT opcode value.
- Adds single-step, pause/resume, a sticky halted state and a retired-instruction counter.
- Sits between the board/debug interface and the datapath stage enables.

Parameters:
IR_WIDTH, 16, width of writeback instruction register wb_ir
OP_MSB, 15, MSB of opcode field in wb_ir
OP_LSB, 11, LSB of opcode field in wb_ir
HALT_OP, 5'b00001, opcode value that halts the core (width OP_MSB-OP_LSB+1)
CNT_WIDTH, 16, width of retired-instruction counter
WDOG_LIMIT, 1024, watchdog cycle limit (used only with CPU_CTRL_WDOG_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  global enable; low forces IDLE from any state
start  input  1  launch continuous execution
step  input  1  execute exactly one instruction
pause  input  1  suspend continuous execution
resume  input  1  continue from PAUSE
wb_valid  input  1  wb_ir holds a retiring instruction this cycle
wb_ir  input  IR_WIDTH  instruction in writeback
state  output  3  current FSM state: IDLE=0, RUN=1, STEP=2, PAUSE=3, HALT=4
run  output  1  pipeline advance enable; combinational, 1 in RUN or STEP
halted  output  1  1 in HALT
retired  output  CNT_WIDTH  retired-instruction count
wdog_trip  output  1  sticky watchdog-timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, retired=0, wdog_trip=0; run=0, halted=0 follow from state.
- is_halt = wb_valid & (wb_ir[OP_MSB:OP_LSB]==HALT_OP).
- All transitions take effect on the next rising clock edge. Priority within each state is as listed, first match wins.
- IDLE:
  - enable&start -> RUN; retired cleared to 0, wdog_trip cleared.
  - enable&step -> STEP; retired not cleared.
  - else stay.
- RUN:
  - !enable -> IDLE.
  - is_halt -> HALT.
  - pause -> PAUSE.
  - else stay.
- STEP (run=1 until one instruction retires):
  - !enable -> IDLE.
  - is_halt -> HALT.
  - wb_valid -> PAUSE.
  - else stay.
- PAUSE:
  - !enable -> IDLE.
  - resume -> RUN.
  - step -> STEP.
  - else stay.
  - resume and step together: resume wins.
- HALT:
  - !enable -> IDLE.
  - start -> IDLE; a second start is needed to relaunch.
  - else stay.
- Invalid encodings (5-7) -> IDLE.
- retired:
  - +1 on each cycle with wb_valid & run; the HALT instruction is counted.
  - Saturates at all-ones; no wrap.
  - Holds in IDLE/PAUSE/HALT.
  - Clear on start from IDLE has priority over increment in that same cycle.
- pause/step/resume are level-sampled each cycle; no edge detection. The host pulses them for one cycle.
- Reset asserted mid-RUN: immediate IDLE, counters zeroed, regardless of clock.

Optional Feature:
CPU_CTRL_WDOG_EN:
- Defined:
  - A cycle counter runs while state is RUN or STEP. It clears on wb_valid and on any entry into RUN/STEP.
  - When the counter reaches WDOG_LIMIT-1 without wb_valid, the next state is IDLE and wdog_trip is set.
  - This has priority below !enable and above is_halt.
  - wdog_trip stays set until reset or start from IDLE.
- Undefined: no watchdog counter; wdog_trip tied 0; WDOG_LIMIT ignored.

Test Plan:
- Reset then enable=1, start pulse; wb_valid every cycle with non-halt opcodes for 10 cycles -> state=RUN, run=1, retired=10.
- In RUN, wb_valid with wb_ir[15:11]=5'b00001 -> next cycle state=HALT, halted=1, run=0, retired increments once more. Start pulse -> IDLE; start again -> RUN with retired=0.
- From IDLE, step pulse; wb_valid low 3 cycles, then high 1 cycle -> run=1 for 4 cycles, then state=PAUSE, retired=1. Resume and step together -> RUN.
- In RUN, pause pulse -> PAUSE, retired frozen while wb_valid toggles. Drop enable in PAUSE -> IDLE next edge.
- Drive reset low asynchronously mid-RUN between clock edges -> state=0, retired=0 immediately. CNT_WIDTH=4 run with 20 retires -> retired=15, no wrap.
- With CPU_CTRL_WDOG_EN, WDOG_LIMIT=8: RUN with wb_valid held low -> after 8 cycles state=IDLE, wdog_trip=1. Start clears wdog_trip. Without the macro -> stays RUN, wdog_trip=0.
